// File: rtl/post_sparsity_ctrl_if.sv
// Bundles the requester, post_sparsity and response buses of post_sparsity_ctrl.
// The master modport is the controller's view; slave is the surrounding fabric.
interface post_sparsity_ctrl_if #(
  parameter int IL     = 4,
  parameter int FL     = 16,
  parameter int LENGTH = 32,
  parameter int NREQ   = 4
);
  localparam int W   = IL + FL;
  localparam int TW  = 16 * W;
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*TW-1:0]     req_im;
  logic [NREQ*LENGTH-1:0] req_mask;

  logic [TW-1:0]          ps_i_im;
  logic [LENGTH-1:0]      ps_i_mask;
  logic                   ps_input_ready;
  logic                   ps_output_taken;
  logic [TW-1:0]          ps_o_im;
  logic [LENGTH-1:0]      ps_o_mask;
  logic [1:0]             ps_state;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [TW-1:0]          rsp_im;
  logic [LENGTH-1:0]      rsp_mask;
  logic                   rsp_err;

  modport master (
    input  req_valid, req_im, req_mask,
    input  ps_o_im, ps_o_mask, ps_state,
    input  rsp_ready,
    output req_ready,
    output ps_i_im, ps_i_mask, ps_input_ready, ps_output_taken,
    output rsp_valid, rsp_id, rsp_im, rsp_mask, rsp_err
  );

  modport slave (
    output req_valid, req_im, req_mask,
    output ps_o_im, ps_o_mask, ps_state,
    output rsp_ready,
    input  req_ready,
    input  ps_i_im, ps_i_mask, ps_input_ready, ps_output_taken,
    input  rsp_valid, rsp_id, rsp_im, rsp_mask, rsp_err
  );
endinterface

// File: rtl/post_sparsity_ctrl.sv
// Round-robin scheduler sharing one post_sparsity unit among NREQ producers,
// with a busy watchdog and a count of tiles completed without error.
module post_sparsity_ctrl #(
  parameter int IL      = 4,
  parameter int FL      = 16,
  parameter int LENGTH  = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  post_sparsity_ctrl_if.master bus,
  output logic [15:0]          tile_count,
  output logic                 busy
);
  localparam int W            = IL + FL;
  localparam int TW           = 16 * W;
  localparam int IDW          = $clog2(NREQ);
  localparam int CW           = $clog2(TIMEOUT);
  localparam int unsigned NR  = NREQ;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t            state, state_nx;
  logic [IDW-1:0]    rr_ptr, rr_nx, gnt_id, gnt_lo, gnt_hi, id_q;
  logic              found_lo, found_hi, any_req;
  logic [CW-1:0]     wcnt;
  logic              ps_done, wd_expire;
  logic [TW-1:0]     ps_i_im_q, rsp_im_q;
  logic [LENGTH-1:0] ps_i_mask_q, rsp_mask_q;
  logic              rsp_err_q;
  logic [NREQ-1:0]   req_ready_c;
  logic              input_ready_c, taken_c;

  assign any_req   = |bus.req_valid;
  assign ps_done   = (bus.ps_state == 2'b10);
  assign wd_expire = (wcnt == CW'(TIMEOUT - 1));

  // Lowest valid index at/after rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    gnt_lo   = '0;
    gnt_hi   = '0;
    found_lo = 1'b0;
    found_hi = 1'b0;
    for (int unsigned j = 0; j < NR; j++) begin
      if (bus.req_valid[j] && !found_lo) begin
        gnt_lo   = IDW'(j);
        found_lo = 1'b1;
      end
      if (bus.req_valid[j] && !found_hi && (j >= 32'(rr_ptr))) begin
        gnt_hi   = IDW'(j);
        found_hi = 1'b1;
      end
    end
    gnt_id = found_hi ? gnt_hi : gnt_lo;
    rr_nx  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    req_ready_c   = '0;
    input_ready_c = 1'b0;
    taken_c       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (any_req) begin
          state_nx            = S_LAUNCH;
          req_ready_c[gnt_id] = 1'b1;
        end
      end
      S_LAUNCH: begin
        input_ready_c = 1'b1;
        state_nx      = S_WAIT;
      end
      S_WAIT: begin
        if (ps_done || wd_expire) state_nx = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          taken_c  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // Pulses are suppressed while reset is held so nothing escapes in the reset cycle.
    if (reset) begin
      req_ready_c   = '0;
      input_ready_c = 1'b0;
      taken_c       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= '0;
      id_q        <= '0;
      wcnt        <= '0;
      ps_i_im_q   <= '0;
      ps_i_mask_q <= '0;
      rsp_im_q    <= '0;
      rsp_mask_q  <= '0;
      rsp_err_q   <= 1'b0;
      tile_count  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            ps_i_im_q   <= bus.req_im[gnt_id*TW +: TW];
            ps_i_mask_q <= bus.req_mask[gnt_id*LENGTH +: LENGTH];
            id_q        <= gnt_id;
            rr_ptr      <= rr_nx;
          end
        end
        S_LAUNCH: wcnt <= '0;
        S_WAIT: begin
          if (ps_done) begin
            rsp_im_q   <= bus.ps_o_im;
            rsp_mask_q <= bus.ps_o_mask;
            rsp_err_q  <= 1'b0;
          end else if (wd_expire) begin
            rsp_im_q   <= '0;
            rsp_mask_q <= '0;
            rsp_err_q  <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready && !rsp_err_q) tile_count <= tile_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready       = req_ready_c;
  assign bus.ps_input_ready  = input_ready_c;
  assign bus.ps_output_taken = taken_c;
  assign bus.ps_i_im         = ps_i_im_q;
  assign bus.ps_i_mask       = ps_i_mask_q;
  assign bus.rsp_valid       = (state == S_RESP);
  assign bus.rsp_id          = id_q;
  assign bus.rsp_im          = rsp_im_q;
  assign bus.rsp_mask        = rsp_mask_q;
  assign bus.rsp_err         = rsp_err_q;
  assign busy                = (state != S_IDLE);
endmodule
